// File: rtl/avl_pattern_burst_writer_pkg.sv
// Shared encodings for the pattern burst writer: FSM states, pattern mode codes
// and the 24-bit RGB colours placed in the low bits of each pixel word.
// Ports: none (package).
package avl_pattern_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_BURST = 4'd2,
    ST_DONE  = 4'd9
  } state_e;

  localparam logic [2:0] MODE_HQUART = 3'd0;
  localparam logic [2:0] MODE_VHALF  = 3'd1;
  localparam logic [2:0] MODE_ALT    = 3'd2;
  localparam logic [2:0] MODE_ADDR   = 3'd3;
  localparam logic [2:0] MODE_BARS   = 3'd4;

  localparam logic [23:0] COL_RED     = 24'hFF0000;
  localparam logic [23:0] COL_GREEN   = 24'h00FF00;
  localparam logic [23:0] COL_BLUE    = 24'h0000FF;
  localparam logic [23:0] COL_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] COL_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] COL_CYAN    = 24'h00FFFF;
  localparam logic [23:0] COL_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] COL_BLACK   = 24'h000000;
  localparam logic [23:0] COL_VHALF_L = 24'h55AA55;
  localparam logic [23:0] COL_VHALF_R = 24'hBB6666;
  localparam logic [23:0] COL_ALT_ODD = 24'h0FFFFF;

endpackage

// File: rtl/avl_pattern_burst_writer_if.sv
// Avalon-MM write-burst bundle between the pattern writer and the LPDDR2 controller.
// Latency: n/a (wires only).
// Backpressure: avl_waitrequest_n low stalls the master with all outputs held.
interface avl_pattern_burst_writer_if #(
  parameter int ADDR_W = 27,
  parameter int DATA_W = 32,
  parameter int BC_W   = 7
);
  logic              avl_waitrequest_n;
  logic [ADDR_W-1:0] avl_address;
  logic [DATA_W-1:0] avl_writedata;
  logic              avl_write;
  logic              avl_burstbegin;
  logic [BC_W-1:0]   avl_burstcount;

  modport master (
    input  avl_waitrequest_n,
    output avl_address, avl_writedata, avl_write, avl_burstbegin, avl_burstcount
  );

  modport slave (
    output avl_waitrequest_n,
    input  avl_address, avl_writedata, avl_write, avl_burstbegin, avl_burstcount
  );
endinterface

// File: rtl/avl_pattern_burst_writer_gen.sv
// Pixel pattern generator: maps (mode, x, y, pixel parity, word address) to a pixel word.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is registered.
module avl_pattern_gen
  import avl_pattern_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 27,
  parameter int H_ACTIVE = 1920,
  parameter int V_ACTIVE = 1080,
  parameter int XW       = 11,
  parameter int YW       = 11
) (
  input  logic [2:0]        mode_i,
  input  logic [XW-1:0]     x_i,
  input  logic [YW-1:0]     y_i,
  input  logic              p_odd_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] data_o
);
  // Bar 7 absorbs the remainder, so bar index is the highest threshold crossed.
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [23:0] rgb;

  always_comb begin
    bar = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(x_i) >= k * BAR_W) bar = 3'(k);
    end

    rgb = COL_BLACK;
    case (mode_i)
      MODE_HQUART: begin
        if (int'(y_i) < V_ACTIVE / 4)              rgb = COL_RED;
        else if (int'(y_i) < V_ACTIVE / 2)         rgb = COL_GREEN;
        else if (int'(y_i) < (3 * V_ACTIVE) / 4)   rgb = COL_BLUE;
        else                                       rgb = COL_WHITE;
      end
      MODE_VHALF: rgb = (int'(x_i) < H_ACTIVE / 2) ? COL_VHALF_L : COL_VHALF_R;
      MODE_ALT:   rgb = p_odd_i ? COL_ALT_ODD : COL_RED;
      MODE_BARS: begin
        case (bar)
          3'd0:    rgb = COL_WHITE;
          3'd1:    rgb = COL_YELLOW;
          3'd2:    rgb = COL_CYAN;
          3'd3:    rgb = COL_GREEN;
          3'd4:    rgb = COL_MAGENTA;
          3'd5:    rgb = COL_RED;
          3'd6:    rgb = COL_BLUE;
          default: rgb = COL_BLACK;
        endcase
      end
      default: rgb = COL_BLACK;
    endcase

    data_o = (mode_i == MODE_ADDR) ? DATA_W'(addr_i) : DATA_W'(rgb);
  end
endmodule

// File: rtl/avl_pattern_burst_writer.sv
// Fills an H_ACTIVE x V_ACTIVE framebuffer with a test pattern via Avalon-MM write bursts.
// Latency: LOAD 3 cycles after button edge; each burst = 1 LOAD cycle + N accepted beats.
// Backpressure: avl_waitrequest_n low holds address/data/burstcount/write, no beat counted.
// Ports: iCLK/iRST_n clock and async reset; iBUTTON/iMODE/local_init_done start control;
// avl master bundle; drv_status_test_complete (DONE), oBUSY (LOAD/BURST), c_state (debug).
module avl_pattern_burst_writer
  import avl_pattern_pkg::*;
#(
  parameter int ADDR_W    = 27,
  parameter int DATA_W    = 32,
  parameter int H_ACTIVE  = 1920,
  parameter int V_ACTIVE  = 1080,
  parameter int BURST_LEN = 8,
  parameter int BC_W      = 7,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     iCLK,
  input  logic                     iRST_n,
  input  logic                     iBUTTON,
  input  logic [2:0]               iMODE,
  input  logic                     local_init_done,
  avl_pattern_burst_writer_if.master avl,
  output logic                     drv_status_test_complete,
  output logic                     oBUSY,
  output logic [3:0]               c_state
);
  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = $clog2(V_ACTIVE + 1);

  // Button synchroniser; idle level is high so a reset never looks like a press.
  logic [1:0] sync_q;
  logic       btn_prev_q;
  logic       start;

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sync_q     <= 2'b11;
      btn_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], iBUTTON};
      btn_prev_q <= sync_q[1];
    end
  end

  assign start = btn_prev_q & ~sync_q[1] & local_init_done;

  state_e            state_q, state_d;
  logic [PW-1:0]     pix_q, pix_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [2:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [BC_W-1:0]   left_q, left_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              write_q, write_d;
  logic              bb_q, bb_d;

  logic              accept;
  logic [PW-1:0]     rem;
  logic [BC_W-1:0]   burst_len;
  logic [DATA_W-1:0] gen_data;

  assign accept    = write_q & avl.avl_waitrequest_n;
  assign rem       = PW'(TOTAL) - pix_q;
  assign burst_len = (rem < PW'(BURST_LEN)) ? BC_W'(rem) : BC_W'(BURST_LEN);

  // Pattern is evaluated on the next-state counters so the data register always
  // holds the pixel that the next accepted beat will carry.
  avl_pattern_gen #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE),
    .XW(XW), .YW(YW)
  ) u_gen (
    .mode_i  (mode_q),
    .x_i     (x_d),
    .y_i     (y_d),
    .p_odd_i (pix_d[0]),
    .addr_i  (BASE_ADDR + ADDR_W'(pix_d)),
    .data_o  (gen_data)
  );

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    bc_d    = bc_q;
    left_d  = left_q;
    data_d  = data_q;
    write_d = write_q;
    bb_d    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_LOAD;
          pix_d   = '0;
          x_d     = '0;
          y_d     = '0;
          mode_d  = iMODE;
        end
      end
      ST_LOAD: begin
        state_d = ST_BURST;
        addr_d  = BASE_ADDR + ADDR_W'(pix_q);
        bc_d    = burst_len;
        left_d  = burst_len;
        data_d  = gen_data;
        write_d = 1'b1;
        bb_d    = 1'b1;
      end
      ST_BURST: begin
        if (accept) begin
          pix_d  = pix_q + PW'(1);
          if (x_q == XW'(H_ACTIVE - 1)) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          left_d = left_q - BC_W'(1);
          data_d = gen_data;
          if (left_q == BC_W'(1)) begin
            write_d = 1'b0;
            state_d = (pix_d == PW'(TOTAL)) ? ST_DONE : ST_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        write_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= ST_IDLE;
      pix_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      bc_q    <= '0;
      left_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      bb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      bc_q    <= bc_d;
      left_q  <= left_d;
      data_q  <= data_d;
      write_q <= write_d;
      bb_q    <= bb_d;
    end
  end

  assign avl.avl_address    = addr_q;
  assign avl.avl_writedata  = data_q;
  assign avl.avl_write      = write_q;
  assign avl.avl_burstbegin = bb_q;
  assign avl.avl_burstcount = bc_q;

  assign drv_status_test_complete = (state_q == ST_DONE);
  assign oBUSY   = (state_q == ST_LOAD) || (state_q == ST_BURST);
  assign c_state = state_q;
endmodule
